// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg
//   Shared definitions for the fetch PC generator: the next-PC source
//   selector and the default geometry constants used by pc_gen_unit and
//   its return-address stack.
package pc_gen_pkg;

  // Source of the next fetch PC, one winner per clock edge.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_TRAP,
    SEL_REDIR,
    SEL_RAS,
    SEL_JUMP,
    SEL_SEQ
  } pc_sel_e;

  localparam int unsigned DEF_INST_BYTES = 4;
  localparam int unsigned DEF_RAS_DEPTH  = 4;

endpackage

// File: rtl/pc_ras.sv
// pc_ras
//   Circular return-address stack. A push when full overwrites the oldest
//   entry and the occupancy count saturates at DEPTH. A pop when empty is
//   ignored. Replace rewrites the top entry in place (call and return in the
//   same instruction). Flush empties the stack without touching storage.
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset (empties the stack)
//   flush    in   discard all entries
//   push     in   write data above the current top
//   pop      in   drop the current top
//   replace  in   overwrite the current top with data
//   data     in   XLEN  value for push / replace
//   top      out  XLEN  current top entry (meaningful only when !empty)
//   empty    out  stack holds no entries
//   full     out  stack holds DEPTH entries
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   sp;       // next free slot; wraps, so a full push lands on the oldest entry
  logic [CW-1:0]   count;
  logic [PW-1:0]   top_idx;

  assign top_idx = sp - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      sp    <= sp - PW'(1);
      count <= count - CW'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after a push wrote it, and leaving it reset-free keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (push)                    mem[sp]      <= data;
      else if (replace && !empty)  mem[top_idx] <= data;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit
//   Fetch PC generator. Holds the registered fetch PC, advances it by
//   INST_BYTES on each accepted fetch, and loads trap, redirect, return,
//   jump/call targets by fixed priority. Calls and returns are predicted
//   through a small circular return-address stack.
// Ports
//   CLK            in   rising-edge clock
//   Reset          in   synchronous, active-high reset
//   stall_i        in   hazard stall: hold the PC
//   fetch_ready_i  in   fetch accepts pc_o this cycle
//   fetch_valid_o  out  pc_o is a valid fetch request (registered)
//   pc_o           out  XLEN current fetch PC (registered)
//   pc_seq_o       out  XLEN pc_o + INST_BYTES, wraps modulo 2^XLEN
//   trap_i/trap_vec_i          take trap to trap_vec_i, flushes the RAS
//   redirect_i/redirect_pc_i   resolved redirect to redirect_pc_i
//   jump_i/jump_pc_i           predicted taken jump; jump_pc_i is also the
//                              call target and the empty-RAS return fallback
//   call_i         in   current pc_o is a call: push pc_seq_o
//   ret_i          in   current pc_o is a return: pop the RAS
//   ras_empty_o    out  RAS holds no entries
//   ras_full_o     out  RAS holds RAS_DEPTH entries
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INST_BYTES   = DEF_INST_BYTES,
  parameter int unsigned     RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_seq_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_pc_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  // Clears the sub-instruction offset bits of every loaded target.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));

  pc_sel_e         sel;
  logic            advance;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_replace;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] next_pc;

  assign pc_seq_o = pc_o + XLEN'(INST_BYTES);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    advance     = fetch_valid_o & fetch_ready_i & ~stall_i;
    sel         = SEL_SEQ;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    if (trap_i) begin
      sel = SEL_TRAP;
    end else if (redirect_i) begin
      sel = SEL_REDIR;
    end else if (!advance) begin
      sel = SEL_HOLD;
    end else if (ret_i) begin
      if (ras_empty_o) begin
        // Nothing to predict from: fall back to jump_pc_i; a coincident call
        // still records its return address.
        sel      = SEL_JUMP;
        ras_push = call_i;
      end else begin
        // Call+return: consume the top and put our own return address there.
        sel         = SEL_RAS;
        ras_replace = call_i;
        ras_pop     = ~call_i;
      end
    end else if (jump_i || call_i) begin
      sel      = SEL_JUMP;
      ras_push = call_i;
    end
  end

  always_comb begin
    case (sel)
      SEL_TRAP:  next_pc = trap_vec_i;
      SEL_REDIR: next_pc = redirect_pc_i;
      SEL_RAS:   next_pc = ras_top;
      SEL_JUMP:  next_pc = jump_pc_i;
      SEL_SEQ:   next_pc = pc_seq_o;
      default:   next_pc = pc_o;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_o          <= RESET_VECTOR;
      fetch_valid_o <= 1'b0;
    end else begin
      // Valid rises on the first edge that sees Reset low; no fetch is
      // accepted before that, so the first advance happens one cycle later.
      fetch_valid_o <= 1'b1;
      if (sel != SEL_HOLD) pc_o <= next_pc & ALIGN_MASK;
    end
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (CLK),
    .reset   (Reset),
    .flush   (trap_i),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_replace),
    .data    (pc_seq_o),
    .top     (ras_top),
    .empty   (ras_empty_o),
    .full    (ras_full_o)
  );

endmodule
